mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Shared-memory port bundle: fetch and data requesters plus the memory side.
// slave = arbiter view, master = pipeline/memory environment view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        dm_req;
  logic        dm_we;
  logic        dm_byte;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        dm_misalign;
  logic        mem_req;
  logic        mem_we;
  logic        mem_byte;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_if;
  logic        stall_mem;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_done,
    input  dm_req, dm_we, dm_byte,
    input  dm_addr, dm_wdata,
    output dm_rdata, dm_done, dm_misalign,
    output mem_req, mem_we, mem_byte,
    output mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_done,
    output dm_req, dm_we, dm_byte,
    output dm_addr, dm_wdata,
    input  dm_rdata, dm_done, dm_misalign,
    input  mem_req, mem_we, mem_byte,
    input  mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between fetch and data stages,
// with a streak counter so back-to-back data traffic cannot starve fetch.
module mem_port_arbiter (
  input  logic clk,
  input  logic rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, BUSY_IF, BUSY_DM, RESP
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  streak_q, streak_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        byte_q, byte_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        resp_dm_q, resp_dm_d;
  logic        misal_q, misal_d;

  logic grant_dm;
  logic misal;

  // Fetch wins a contested grant once data has won three in a row.
  assign grant_dm = bus.dm_req &
    ~(bus.if_req & (streak_q == 2'd3));
  assign misal = ~bus.dm_byte &
    (bus.dm_addr[1:0] != 2'b00);

  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    byte_d     = byte_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    resp_dm_d  = resp_dm_q;
    misal_d    = misal_q;
    unique case (state_q)
      IDLE: begin
        if (grant_dm) begin
          if (bus.if_req && streak_q != 2'd3)
            streak_d = streak_q + 2'd1;
          resp_dm_d = 1'b1;
          if (misal) begin
            misal_d = 1'b1;
            state_d = RESP;
          end else begin
            misal_d = 1'b0;
            addr_d  = bus.dm_addr;
            wdata_d = bus.dm_wdata;
            we_d    = bus.dm_we;
            byte_d  = bus.dm_byte;
            state_d = BUSY_DM;
          end
        end else if (bus.if_req) begin
          streak_d  = 2'd0;
          resp_dm_d = 1'b0;
          misal_d   = 1'b0;
          addr_d    = bus.if_addr;
          wdata_d   = '0;
          we_d      = 1'b0;
          byte_d    = 1'b0;
          state_d   = BUSY_IF;
        end
      end
      BUSY_IF: begin
        if (bus.mem_ack) begin
          if_rdata_d = bus.mem_rdata;
          state_d    = RESP;
        end
      end
      BUSY_DM: begin
        if (bus.mem_ack) begin
          dm_rdata_d = bus.mem_rdata;
          state_d    = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      byte_q     <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      resp_dm_q  <= 1'b0;
      misal_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      byte_q     <= byte_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      resp_dm_q  <= resp_dm_d;
      misal_q    <= misal_d;
    end
  end

  logic busy;
  logic resp;

  assign busy = (state_q == BUSY_IF) |
                (state_q == BUSY_DM);
  assign resp = (state_q == RESP);

  assign bus.mem_req     = busy;
  assign bus.mem_we      = busy & we_q;
  assign bus.mem_byte    = busy & byte_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.dm_rdata    = dm_rdata_q;
  assign bus.if_done     = resp & ~resp_dm_q;
  assign bus.dm_done     = resp & resp_dm_q;
  assign bus.dm_misalign = resp & resp_dm_q & misal_q;
  assign bus.stall_if    = bus.if_req & ~bus.if_done;
  assign bus.stall_mem   = bus.dm_req & ~bus.dm_done;

endmodule
